// File: rtl/accumulator_pkg.sv
// Shared types and width helpers for the accumulator drain path.
package accumulator_pkg;

  localparam int DEFAULT_SMALLEST_ELEMENT_WIDTH = 4;
  localparam int DATA_W = 4 * DEFAULT_SMALLEST_ELEMENT_WIDTH;

  typedef enum logic [1:0] {
    BW_4    = 2'd0,
    BW_8    = 2'd1,
    BW_16   = 2'd2,
    BW_RSVD = 2'd3
  } bitwidth_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } drain_state_e;

endpackage

// File: rtl/acc_relu_lanes.sv
// Per-lane ReLU over a packed accumulator word; lane width follows the element bitwidth code.
module acc_relu_lanes
  import accumulator_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] data_i,
  input  bitwidth_e        bitwidth_i,
  output logic [WIDTH-1:0] data_o
);

  // Each bit is cleared when the sign bit of the lane containing it is set.
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    localparam int M4  = (b / 4) * 4 + 3;
    localparam int M8  = (b / 8) * 8 + 7;
    localparam int M16 = (b / 16) * 16 + 15;
    logic neg;
    assign neg = (bitwidth_i == BW_4) ? data_i[M4] :
                 (bitwidth_i == BW_8) ? data_i[M8] : data_i[M16];
    assign data_o[b] = neg ? 1'b0 : data_i[b];
  end

endmodule

// File: rtl/accumulator_drain.sv
// Streams every bank/entry of the read accumulator buffer over valid/ready.
// Optional per-lane ReLU on the output word when ACC_DRAIN_RELU_EN is defined.
module accumulator_drain
  import accumulator_pkg::*;
#(
  parameter int BUFFER_WIDTH           = 8,
  parameter int TILE_SIZE              = 256,
  parameter int SMALLEST_ELEMENT_WIDTH = 4,
  parameter int BANK_COUNT             = 256,
  localparam int WORD_W  = 4 * SMALLEST_ELEMENT_WIDTH,
  localparam int ENTRY_W = $clog2(BUFFER_WIDTH),
  localparam int BANK_W  = $clog2(TILE_SIZE)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [1:0]         bitwidth,
  output logic               busy,
  output logic               done,
  output logic [ENTRY_W-1:0] acc_bank_entry,
  output logic [BANK_W-1:0]  acc_bank_read,
  input  logic [WORD_W-1:0]  acc_data_read,
  output logic [WORD_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last
);

  localparam logic [BANK_W-1:0]  LAST_BANK  = BANK_W'(BANK_COUNT - 1);
  localparam logic [ENTRY_W-1:0] LAST_ENTRY = ENTRY_W'(BUFFER_WIDTH - 1);

  drain_state_e       state_q, state_d;
  logic [BANK_W-1:0]  bank_q, bank_d;
  logic [ENTRY_W-1:0] entry_q, entry_d;
  bitwidth_e          bw_q, bw_d;
  logic [WORD_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               done_q, done_d;
  logic [WORD_W-1:0]  word_f;
  logic               load;
  logic               final_addr;

`ifdef ACC_DRAIN_RELU_EN
  acc_relu_lanes #(.WIDTH(WORD_W)) u_relu (
    .data_i     (acc_data_read),
    .bitwidth_i (bw_q),
    .data_o     (word_f)
  );
`else
  logic bw_unused;
  assign word_f    = acc_data_read;
  assign bw_unused = ^bw_q;
`endif

  always_comb begin
    state_d    = state_q;
    bank_d     = bank_q;
    entry_d    = entry_q;
    bw_d       = bw_q;
    data_d     = data_q;
    valid_d    = valid_q;
    last_d     = last_q;
    done_d     = 1'b0;
    load       = (state_q == RUN) && (!valid_q || out_ready);
    final_addr = (bank_q == LAST_BANK) && (entry_q == LAST_ENTRY);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          bank_d  = '0;
          entry_d = '0;
          bw_d    = bitwidth_e'(bitwidth);
        end
      end
      RUN: begin
        // Final address is held rather than wrapped; the last word drains in FLUSH.
        if (load) begin
          if (final_addr) begin
            state_d = FLUSH;
          end else if (entry_q == LAST_ENTRY) begin
            entry_d = '0;
            bank_d  = bank_q + 1'b1;
          end else begin
            entry_d = entry_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (valid_q && out_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      data_d  = word_f;
      valid_d = 1'b1;
      last_d  = final_addr;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      bank_q  <= '0;
      entry_q <= '0;
      bw_q    <= BW_4;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      entry_q <= entry_d;
      bw_q    <= bw_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign acc_bank_entry = entry_q;
  assign acc_bank_read  = bank_q;
  assign out_data       = data_q;
  assign out_valid      = valid_q;
  assign out_last       = last_q;

endmodule

// File: tb/tb_accumulator_drain.sv
// Directed bench for accumulator_drain with a 4-bank x 2-entry buffer model.
module tb_accumulator_drain;

  localparam int BANKS   = 4;
  localparam int ENTRIES = 2;
  localparam int WORDS   = BANKS * ENTRIES;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  bitwidth;
  logic        busy, done;
  logic [0:0]  acc_bank_entry;
  logic [7:0]  acc_bank_read;
  logic [15:0] acc_data_read;
  logic [15:0] out_data;
  logic        out_valid, out_ready, out_last;

  logic        ovr_en;
  logic [15:0] ovr_data;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]  bw;
    logic [15:0] din;
    logic [15:0] exp_relu;
  } relu_vec_t;

  relu_vec_t vecs[8];

  always #5 clk = ~clk;

  // Bank model: word = {bank, entry}, or a forced value for the ReLU vectors.
  assign acc_data_read = ovr_en ? ovr_data : {acc_bank_read, 7'b0, acc_bank_entry};

  accumulator_drain #(
    .BUFFER_WIDTH           (ENTRIES),
    .TILE_SIZE              (256),
    .SMALLEST_ELEMENT_WIDTH (4),
    .BANK_COUNT             (BANKS)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .bitwidth       (bitwidth),
    .busy           (busy),
    .done           (done),
    .acc_bank_entry (acc_bank_entry),
    .acc_bank_read  (acc_bank_read),
    .acc_data_read  (acc_data_read),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input int k);
    logic [15:0] w;
    w       = '0;
    w[15:8] = 8'(k / ENTRIES);
    w[0]    = 1'(k % ENTRIES);
    return w;
  endfunction

  // mode 0: ready high; 1: random ready; 2: extra start at word 3; 3: leave start high in done cycle
  task automatic run_drain(input int mode, input bit issue_start, input logic [1:0] bw);
    int k, cyc, last_cyc, done_cyc;
    bit stalled, restarted;
    logic [15:0] held;
    k = 0; cyc = 0; last_cyc = -1; done_cyc = -1;
    stalled = 1'b0; restarted = 1'b0; held = '0;
    if (issue_start) begin
      @(posedge clk); #1;
      start = 1'b1;
      bitwidth = bw;
    end
    @(posedge clk); #1;
    start = 1'b0;
    out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    check("busy_after_start", 32'(busy), 32'd1);
    check("valid_before_first_load", 32'(out_valid), 32'd0);
    while (done_cyc < 0 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      start = (mode == 2 && k == 3 && !restarted);
      if (start) restarted = 1'b1;
      @(negedge clk);
      if (cyc == 1) check("first_valid_latency", 32'(out_valid), 32'd1);
      if (done) begin
        done_cyc = cyc;
        check("done_after_last_handshake", 32'(cyc), 32'(last_cyc + 1));
        check("busy_low_at_done", 32'(busy), 32'd0);
        check("word_count", 32'(k), 32'(WORDS));
      end
      if (stalled) begin
        check("stall_valid_hold", 32'(out_valid), 32'd1);
        check("stall_data_hold", 32'(out_data), 32'(held));
      end
      if (out_valid) begin
        if (out_ready) begin
          check($sformatf("word%0d_data", k), 32'(out_data), 32'(exp_word(k)));
          check($sformatf("word%0d_last", k), 32'(out_last), 32'(k == WORDS - 1));
          if (k == WORDS - 1) last_cyc = cyc;
          k++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = out_data;
        end
      end else begin
        stalled = 1'b0;
      end
    end
    if (done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
    if (mode == 3) begin
      start = 1'b1;
    end else begin
      @(posedge clk); #1;
      @(negedge clk);
      check("done_single_pulse", 32'(done), 32'd0);
      check("valid_low_after_done", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] exp;
    int c;
    vecs[0] = '{2'd1, 16'h807F, 16'h007F};
    vecs[1] = '{2'd0, 16'h8A71, 16'h0071};
    vecs[2] = '{2'd1, 16'hF81A, 16'h001A};
    vecs[3] = '{2'd2, 16'h8001, 16'h0000};
    vecs[4] = '{2'd3, 16'h7FFF, 16'h7FFF};
    vecs[5] = '{2'd2, 16'h1234, 16'h1234};
    vecs[6] = '{2'd0, 16'h7878, 16'h7070};
    vecs[7] = '{2'd3, 16'h8000, 16'h0000};

    reset_n = 1'b1; start = 1'b0; bitwidth = 2'd0; out_ready = 1'b0;
    ovr_en = 1'b0; ovr_data = '0;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_bank", 32'(acc_bank_read), 32'd0);
    check("rst_entry", 32'(acc_bank_entry), 32'd0);
    reset_n = 1'b1;

    run_drain(0, 1'b1, 2'd0);
    run_drain(1, 1'b1, 2'd0);
    run_drain(2, 1'b1, 2'd0);

    // Reset while the fifth word is on the output.
    @(posedge clk); #1;
    start = 1'b1; bitwidth = 2'd0; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("pre_reset_word4", 32'(out_data), 32'(exp_word(4)));
    reset_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_data", 32'(out_data), 32'd0);
    check("midrst_bank", 32'(acc_bank_read), 32'd0);
    check("midrst_entry", 32'(acc_bank_entry), 32'd0);
    @(negedge clk);
    check("midrst_no_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    run_drain(0, 1'b1, 2'd0);

    // Back-to-back tiles: second start lands in the done cycle.
    run_drain(3, 1'b1, 2'd0);
    run_drain(0, 1'b0, 2'd0);

    ovr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
`ifdef ACC_DRAIN_RELU_EN
      exp = vecs[i].exp_relu;
`else
      exp = vecs[i].din;
`endif
      ovr_data = vecs[i].din;
      @(posedge clk); #1;
      start = 1'b1; bitwidth = vecs[i].bw; out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      bitwidth = ~vecs[i].bw;
      @(negedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_first", i), 32'(out_data), 32'(exp));
      c = 0;
      while (!done && c < 20) begin
        if (out_valid && out_last)
          check($sformatf("vec%0d_last_word", i), 32'(out_data), 32'(exp));
        @(negedge clk);
        c++;
      end
      check($sformatf("vec%0d_done", i), 32'(done), 32'd1);
    end
    ovr_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
